// File: rtl/shift_seq8_if.sv
// shift_seq8_if -- command/result bundle for the shift_seq8 multi-cycle shifter.
// The master issues commands (start/op/shamt/d_in).
// The slave (the shifter) reports busy/done/d_out.
interface shift_seq8_if;
    logic       start;
    logic [1:0] op;
    logic [3:0] shamt;
    logic [7:0] d_in;
    logic       busy;
    logic       done;
    logic [7:0] d_out;

    modport master (
        output start,
        output op,
        output shamt,
        output d_in,
        input  busy,
        input  done,
        input  d_out
    );

    modport slave (
        input  start,
        input  op,
        input  shamt,
        input  d_in,
        output busy,
        output done,
        output d_out
    );
endinterface

// File: rtl/shift_seq8.sv
// shift_seq8 -- 8-bit multi-cycle shifter.
// A total shift of 0..15 is built from passes of at most 3 positions.
// Every pass goes through one shared 2-bit-amount shift stage.
// Operations: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
// Optional feature macro: SHIFT_SEQ8_ROR_EN enables rotate-right for op=11.
// Without it, op=11 completes immediately and returns the operand unchanged.
module shift_seq8 (
    input  logic         clk,
    input  logic         reset_n,
    shift_seq8_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] work_q,  work_d;
    logic [1:0] op_q,    op_d;
    logic [3:0] rem_q,   rem_d;
    logic [7:0] d_out_q, d_out_d;
    logic       busy_q,  busy_d;
    logic       done_q,  done_d;

    logic [1:0] step;
    logic [7:0] shifted;
    logic       skip_op;

    // One pass of the shared shift stage: shift w by amt (0..3) according to op.
    function automatic logic [7:0] shift_pass(input logic [7:0] w,
                                              input logic [1:0] sel,
                                              input logic [1:0] amt);
        logic [7:0]  res;
        logic [15:0] rot;
        res = w;
        rot = 16'h0000;
        case (sel)
            2'b00:   res = w << amt;
            2'b01:   res = w >> amt;
            2'b10:   res = $signed(w) >>> amt;
            default: begin
`ifdef SHIFT_SEQ8_ROR_EN
                rot = {w, w} >> amt;
                res = rot[7:0];
`else
                rot = {8'h00, w};
                res = rot[7:0];
`endif
            end
        endcase
        return res;
    endfunction

    // Pass size and shifted working value for the current SHIFT cycle.
    always_comb begin
        step    = (rem_q > 4'd3) ? 2'd3 : rem_q[1:0];
        shifted = shift_pass(work_q, op_q, step);
`ifdef SHIFT_SEQ8_ROR_EN
        skip_op = 1'b0;
`else
        skip_op = (bus.op == 2'b11);
`endif
    end

    // Next-state logic: command acceptance, pass sequencing and result capture.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        op_d    = op_q;
        rem_d   = rem_q;
        d_out_d = d_out_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    work_d = bus.d_in;
                    op_d   = bus.op;
                    if (skip_op || bus.shamt == 4'd0) begin
                        rem_d   = 4'd0;
                        state_d = DONE;
                    end else begin
                        rem_d   = bus.shamt;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d  = shifted;
                rem_d   = rem_q - {2'b00, step};
                state_d = (rem_d == 4'd0) ? DONE : SHIFT;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        if (state_d == DONE && state_q != DONE) begin
            d_out_d = work_d;
        end
    end

    // State, datapath and registered outputs, all cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            work_q  <= 8'h00;
            op_q    <= 2'b00;
            rem_q   <= 4'd0;
            d_out_q <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            d_out_q <= d_out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.d_out = d_out_q;

endmodule

// File: tb/tb_shift_seq8.sv
// tb_shift_seq8 -- self-checking bench for shift_seq8.
// A reference model computes the total shift directly with integer arithmetic.
// Honours SHIFT_SEQ8_ROR_EN the same way as the design.
module tb_shift_seq8;

    logic clk;
    logic reset_n;
    int   errors;
    int   checks;
    logic [7:0] held_out;

    shift_seq8_if bus ();

    shift_seq8 dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result of a whole command.
    function automatic logic [7:0] refShift(input int op, input int s, input int d);
        int v;
        int r;
        v = d;
        case (op)
            0: v = (d << s) & 255;
            1: v = d >> s;
            2: v = (((d >= 128) ? d - 256 : d) >>> s) & 255;
            default: begin
`ifdef SHIFT_SEQ8_ROR_EN
                r = s % 8;
                v = ((d >> r) | (d << (8 - r))) & 255;
`else
                r = 0;
                v = d;
`endif
            end
        endcase
        return v[7:0];
    endfunction

    // Number of shift passes a command needs.
    function automatic int passes(input int op, input int s);
`ifndef SHIFT_SEQ8_ROR_EN
        if (op == 3) return 0;
`endif
        return (s + 2) / 3;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Issue one command and follow it cycle by cycle until the DUT is back in IDLE.
    // Extra start pulses with other data are driven while busy and during done.
    task automatic applyStimulus(input int op, input int s, input logic [7:0] d,
                                 input logic [7:0] mid_d, input logic [7:0] exp_out);
        int n;
        n = passes(op, s);
        bus.start = 1'b1;
        bus.op    = op[1:0];
        bus.shamt = s[3:0];
        bus.d_in  = d;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.d_in  = mid_d;
        bus.op    = 2'($urandom);
        bus.shamt = 4'($urandom);
        checkOutput("busy_accept", 32'(bus.busy), 32'd1);
        checkOutput("done_accept", 32'(bus.done), 32'(n == 0));
        checkOutput("dout_accept", 32'(bus.d_out), 32'((n == 0) ? exp_out : held_out));
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            bus.d_in  = 8'($urandom);
            bus.op    = 2'($urandom);
            bus.shamt = 4'($urandom);
            checkOutput("busy_shift", 32'(bus.busy), 32'd1);
            checkOutput("done_shift", 32'(bus.done), 32'(i == n));
            checkOutput("dout_shift", 32'(bus.d_out), 32'((i == n) ? exp_out : held_out));
        end
        held_out = exp_out;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("busy_after", 32'(bus.busy), 32'd0);
        checkOutput("done_after", 32'(bus.done), 32'd0);
        checkOutput("dout_after", 32'(bus.d_out), 32'(held_out));
    endtask

    initial begin
        int op;
        int s;
        logic [7:0] d;
        errors    = 0;
        checks    = 0;
        held_out  = 8'h00;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.shamt = 4'd0;
        bus.d_in  = 8'h00;
        reset_n   = 1'b1;
        #2;
        reset_n   = 1'b0;
        #1;
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_dout", 32'(bus.d_out), 32'h00);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        $display("[TB] directed commands");
        applyStimulus(2, 5, 8'h90, 8'h01, 8'hFC);
        applyStimulus(0, 7, 8'h81, 8'h55, 8'h80);
        applyStimulus(1, 15, 8'hF0, 8'hFF, 8'h00);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(k, 0, 8'h3C, 8'hC3, 8'h3C);
        end
`ifdef SHIFT_SEQ8_ROR_EN
        applyStimulus(3, 4, 8'hA5, 8'h12, 8'h5A);
`else
        applyStimulus(3, 4, 8'hA5, 8'h12, 8'hA5);
`endif
        applyStimulus(2, 15, 8'h80, 8'h00, 8'hFF);
        applyStimulus(2, 9, 8'h7F, 8'h80, 8'h00);

        $display("[TB] reset in the middle of a command");
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.shamt = 4'd5;
        bus.d_in  = 8'h90;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("abort_busy_pre", 32'(bus.busy), 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_done", 32'(bus.done), 32'd0);
        checkOutput("abort_dout", 32'(bus.d_out), 32'h00);
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        held_out = 8'h00;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            checkOutput("abort_no_done", 32'(bus.done), 32'd0);
            checkOutput("abort_idle", 32'(bus.busy), 32'd0);
            checkOutput("abort_dout_held", 32'(bus.d_out), 32'h00);
        end
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        applyStimulus(0, 7, 8'h81, 8'h33, 8'h80);

        $display("[TB] randomized commands");
        for (int k = 0; k < 40; k++) begin
            op = int'($urandom_range(0, 3));
            s  = int'($urandom_range(0, 15));
            d  = 8'($urandom);
            applyStimulus(op, s, d, 8'($urandom), refShift(op, s, int'(d)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_seq8.md
SHIFT_SEQ8 -- requirements
Module: shift_seq8

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports SHALL be named clk and reset_n.
REQ-002 The ports SHALL be, one per line:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  command request, sampled only in IDLE
- op  input  2  operation: 00 LSL, 01 LSR, 10 ASR, 11 ROR (see REQ-020)
- shamt  input  4  total shift amount, 0..15
- d_in  input  8  operand
- busy  output  1  high while a command is in progress (SHIFT or DONE)
- done  output  1  one-cycle pulse; d_out valid
- d_out  output  8  registered result, held until the next accepted command
REQ-003 The block SHALL have no parameters; width is fixed at 8 bits and the per-pass shift range at 0..3.

Function
REQ-004 The block SHALL implement a multi-cycle shifter that composes a total shift of 0..15 from passes of at most 3 positions each, through one shared 2-bit-amount shift stage.
REQ-005 The FSM SHALL have the states IDLE, SHIFT and DONE.
REQ-006 Transitions SHALL be:
- IDLE -> SHIFT on start=1 with shamt!=0
- IDLE -> DONE on start=1 with shamt=0
- SHIFT -> SHIFT while the remaining shift after the current pass is nonzero
- SHIFT -> DONE when the remaining shift after the current pass is 0
- DONE -> IDLE unconditionally
REQ-007 On acceptance, the block SHALL latch d_in into the working register, latch op, and load the remaining count with shamt; input changes afterwards SHALL NOT affect the command.
REQ-008 Each SHIFT cycle SHALL apply step = min(remaining, 3) to the working register and decrement remaining by step.
REQ-009 Fill rules per pass:
- LSL and LSR fill with 0.
- ASR replicates bit 7 of the working register.
- ROR re-enters bits shifted out at bit 7.
REQ-010 The number of passes SHALL be N = ceil(shamt/3): N=0 for shamt=0, N=5 for shamt=13..15.
REQ-011 done SHALL be high for exactly one cycle, in DONE, which is entered on the (N+1)th rising edge, counting the accepting edge as the first.
REQ-012 On entering DONE, d_out SHALL be loaded with the working register; d_out SHALL NOT change at any other time except reset.
REQ-013 busy SHALL be high in SHIFT and DONE, and low in IDLE.
REQ-014 start SHALL be ignored while busy=1; no command is queued.
REQ-015 A start asserted in the cycle where done=1 SHALL be ignored; the earliest acceptance is the following IDLE cycle.
REQ-016 shamt of 8 or more SHALL complete normally:
- LSL and LSR yield 8'h00.
- ASR yields all copies of the original bit 7.
- ROR yields the rotate by shamt mod 8.

Reset
REQ-017 While reset_n=0, the block SHALL assert reset asynchronously, giving state IDLE, busy=0, done=0, d_out=8'h00, a cleared working register and remaining count=0.
REQ-018 Reset asserted mid-command SHALL abort the command, with no done pulse, and d_out SHALL become 8'h00.
REQ-019 After deassertion, the first rising edge SHALL be able to accept a command.

Configuration
REQ-020 The macro SHIFT_SEQ8_ROR_EN SHALL control op=11:
- Defined: op=11 performs rotate-right per REQ-009.
- Undefined: op=11 is accepted, no passes run (as for shamt=0), and d_out equals the latched d_in with done on the 1st edge after acceptance.
REQ-021 All other behaviour SHALL be identical with and without SHIFT_SEQ8_ROR_EN.

Verification
REQ-022 ASR, d_in=8'h90, shamt=5 -> 2 SHIFT cycles; done on the 3rd edge after acceptance; d_out=8'hFC.
REQ-023 LSL, d_in=8'h81, shamt=7 -> 3 passes (3,3,1); d_out=8'h80; busy high for 4 cycles.
REQ-024 LSR, d_in=8'hF0, shamt=15 -> 5 passes; d_out=8'h00.
REQ-025 shamt=0, d_in=8'h3C, any op -> done on the 1st edge after acceptance; d_out=8'h3C.
REQ-026 ROR, d_in=8'hA5, shamt=4:
- With SHIFT_SEQ8_ROR_EN defined -> d_out=8'h5A.
- Without it -> d_out=8'hA5, with done after 1 edge.
REQ-027 Start the ASR 8'h90/5 command, then pulse start with d_in=8'h01 mid-SHIFT, then assert reset_n=0 for 1 cycle on a second run mid-SHIFT:
- The first run yields d_out=8'hFC, unaffected by the mid-SHIFT start.
- After the reset, busy=0, done never pulses, and d_out=8'h00.
